// File: rtl/ooo_rename_frontend.sv
// ooo_rename_frontend
// In-order front end of the out-of-order core. It fetches RV32I words from an
// internal instruction memory, decodes the register fields, and renames them
// through a map table, a physical-register free list and a ROB tag counter.
// The renamed micro-op is registered toward the dispatch skid buffer.
//
// Optional build macro: OOO_RETIRE_PORT_EN adds a retire port. Each retire
// frees one ROB slot and can push one physical register back on the free list.
// Without it, resources never return.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   imem_we/waddr/wdata   program-load write port, accepted any cycle
//   dispatch_ready        downstream accepts the presented renamed op
//   rename_valid          renamed op valid
//   rename_prs1/prs2      physical sources
//   rename_prd            current free-list head (allocated only if op writes rd!=0)
//   rename_rob_tag        ROB tag of the op
//   rename_instr          raw instruction word
//   retire_valid, retire_free_preg, retire_free_en   (OOO_RETIRE_PORT_EN only)
module ooo_rename_frontend #(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int PHYS_REGS  = 128,
  parameter int ROB_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [XLEN-1:0]               imem_wdata,
  input  logic                          dispatch_ready,
`ifdef OOO_RETIRE_PORT_EN
  input  logic                          retire_valid,
  input  logic [$clog2(PHYS_REGS)-1:0]  retire_free_preg,
  input  logic                          retire_free_en,
`endif
  output logic                          rename_valid,
  output logic [$clog2(PHYS_REGS)-1:0]  rename_prs1,
  output logic [$clog2(PHYS_REGS)-1:0]  rename_prs2,
  output logic [$clog2(PHYS_REGS)-1:0]  rename_prd,
  output logic [$clog2(ROB_DEPTH)-1:0]  rename_rob_tag,
  output logic [XLEN-1:0]               rename_instr
);

  localparam int IADDR_W  = $clog2(IMEM_DEPTH);
  localparam int PTAG_W   = $clog2(PHYS_REGS);
  localparam int ROB_W    = $clog2(ROB_DEPTH);
  localparam int FL_DEPTH = PHYS_REGS - 32;
  localparam int FL_PTR_W = $clog2(FL_DEPTH);
  localparam int FL_CNT_W = $clog2(FL_DEPTH + 1);

  typedef struct packed {
    logic legal;
    logic use1;
    logic use2;
    logic wr;
  } dec_t;

  function automatic dec_t decode_op(input logic [6:0] op);
    dec_t d;
    d = '0;
    case (op)
      7'b0110011:                         d = '{legal: 1'b1, use1: 1'b1, use2: 1'b1, wr: 1'b1};
      7'b0010011, 7'b0000011, 7'b1100111: d = '{legal: 1'b1, use1: 1'b1, use2: 1'b0, wr: 1'b1};
      7'b0100011, 7'b1100011:             d = '{legal: 1'b1, use1: 1'b1, use2: 1'b1, wr: 1'b0};
      7'b0110111, 7'b0010111, 7'b1101111: d = '{legal: 1'b1, use1: 1'b0, use2: 1'b0, wr: 1'b1};
      default:                            d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [FL_PTR_W-1:0] fl_next(input logic [FL_PTR_W-1:0] p);
    return (32'(p) == FL_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  logic [XLEN-1:0]     imem [IMEM_DEPTH];
  logic [PTAG_W-1:0]   map_tbl [32];
  logic [PTAG_W-1:0]   fl_mem [FL_DEPTH];
  logic [IADDR_W-1:0]  pc;
  logic [XLEN-1:0]     instr_p0;
  logic                vld_p0;
  logic [FL_PTR_W-1:0] fl_head;
  logic [FL_PTR_W-1:0] fl_tail;
  logic [FL_CNT_W-1:0] fl_cnt;
  logic [ROB_W-1:0]    rob_tag_cnt;
  logic [ROB_W:0]      in_flight;

  dec_t              dec;
  logic [4:0]        rs1, rs2, rd;
  logic              needs_alloc, hold, fire_ok, struct_stall, advance, fire, alloc;
  logic [PTAG_W-1:0] head_preg;
  logic              ret_ok, push_ok;
  logic [PTAG_W-1:0] push_preg;

  assign dec         = decode_op(instr_p0[6:0]);
  assign rs1         = dec.use1 ? instr_p0[19:15] : 5'd0;
  assign rs2         = dec.use2 ? instr_p0[24:20] : 5'd0;
  assign rd          = instr_p0[11:7];
  assign needs_alloc = dec.wr && (rd != 5'd0);
  assign head_preg   = fl_mem[fl_head];

  // A presented op that downstream refuses freezes the whole front end.
  assign hold         = rename_valid && !dispatch_ready;
  assign fire_ok      = vld_p0 && dec.legal;
  assign struct_stall = fire_ok && ((needs_alloc && fl_cnt == '0) || 32'(in_flight) == ROB_DEPTH);
  // Bubbles still advance the PC; a structural stall keeps the fetched word parked.
  assign advance      = !hold && !struct_stall;
  assign fire         = advance && fire_ok;
  assign alloc        = fire && needs_alloc;

`ifdef OOO_RETIRE_PORT_EN
  assign ret_ok    = retire_valid && (in_flight != '0);
  assign push_ok   = retire_valid && retire_free_en && (retire_free_preg != '0) &&
                     (32'(fl_cnt) != FL_DEPTH);
  assign push_preg = retire_free_preg;
`else
  assign ret_ok    = 1'b0;
  assign push_ok   = 1'b0;
  assign push_preg = '0;
`endif

  // Stage p0: program load and synchronous instruction fetch
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
    if (advance) instr_p0 <= imem[pc];
  end

  // Stage p1: rename into the registered output plus all rename state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= '0;
      vld_p0 <= 1'b0;
      for (int i = 0; i < 32; i++) map_tbl[i] <= PTAG_W'(i);
      for (int i = 0; i < FL_DEPTH; i++) fl_mem[i] <= PTAG_W'(32 + i);
      fl_head        <= '0;
      fl_tail        <= '0;
      fl_cnt         <= FL_CNT_W'(FL_DEPTH);
      rob_tag_cnt    <= '0;
      in_flight      <= '0;
      rename_valid   <= 1'b0;
      rename_prs1    <= '0;
      rename_prs2    <= '0;
      rename_prd     <= '0;
      rename_rob_tag <= '0;
      rename_instr   <= '0;
    end else begin
      if (advance) begin
        pc     <= pc + 1'b1;
        vld_p0 <= 1'b1;
      end
      if (!hold) begin
        rename_valid <= fire;
        rename_prd   <= head_preg;
        if (fire) begin
          // The map already holds the previous op's update, so RAW needs no bypass.
          rename_prs1    <= map_tbl[rs1];
          rename_prs2    <= map_tbl[rs2];
          rename_rob_tag <= rob_tag_cnt;
          rename_instr   <= instr_p0;
        end
      end
      if (fire) rob_tag_cnt <= rob_tag_cnt + 1'b1;
      if (alloc) begin
        map_tbl[rd] <= head_preg;
        fl_head     <= fl_next(fl_head);
      end
      if (push_ok) begin
        fl_mem[fl_tail] <= push_preg;
        fl_tail         <= fl_next(fl_tail);
      end
      fl_cnt    <= fl_cnt + {{(FL_CNT_W-1){1'b0}}, push_ok} - {{(FL_CNT_W-1){1'b0}}, alloc};
      in_flight <= in_flight + {{ROB_W{1'b0}}, fire} - {{ROB_W{1'b0}}, ret_ok};
    end
  end

endmodule

// File: tb/tb_ooo_rename_frontend.sv
module tb_ooo_rename_frontend;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        dispatch_ready;
  logic        rename_valid;
  logic [6:0]  rename_prs1, rename_prs2, rename_prd;
  logic [3:0]  rename_rob_tag;
  logic [31:0] rename_instr;
`ifdef OOO_RETIRE_PORT_EN
  logic        retire_valid;
  logic [6:0]  retire_free_preg;
  logic        retire_free_en;
`endif

  always #5 clk = ~clk;

  ooo_rename_frontend dut (
    .clk            (clk),
    .rst            (rst),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .dispatch_ready (dispatch_ready),
`ifdef OOO_RETIRE_PORT_EN
    .retire_valid     (retire_valid),
    .retire_free_preg (retire_free_preg),
    .retire_free_en   (retire_free_en),
`endif
    .rename_valid   (rename_valid),
    .rename_prs1    (rename_prs1),
    .rename_prs2    (rename_prs2),
    .rename_prd     (rename_prd),
    .rename_rob_tag (rename_rob_tag),
    .rename_instr   (rename_instr)
  );

  localparam logic [31:0] I_ADD   = {7'b0000000, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011};
  localparam logic [31:0] I_SUB   = {7'b0100000, 5'd5, 5'd1, 3'b000, 5'd4, 7'b0110011};
  localparam logic [31:0] I_ADDI0 = {12'd10, 5'd4, 3'b000, 5'd0, 7'b0010011};
  localparam logic [31:0] I_ADDI6 = {12'd100, 5'd0, 3'b000, 5'd6, 7'b0010011};
  localparam logic [31:0] I_BEQ   = {1'b0, 6'd0, 5'd4, 5'd6, 3'b000, 4'b0100, 1'b0, 7'b1100011};

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] prog[$];
  logic [57:0] exp_q[$];
  logic [6:0]  ops[11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                           7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0000000,
                           7'b1111111};

  function automatic logic [57:0] pack_out();
    return {rename_valid, rename_prs1, rename_prs2, rename_prd, rename_rob_tag, rename_instr};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Holds reset while loading the whole memory (program then zeros).
  task automatic load_in_reset();
    rst = 1'b1;
    for (int a = 0; a < 256; a++) begin
      tick();
      imem_we    = 1'b1;
      imem_waddr = 8'(a);
      imem_wdata = (a < prog.size()) ? prog[a] : 32'd0;
    end
    tick();
    imem_we = 1'b0;
  endtask

  task automatic release_rst();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [57:0] got;
    prog = '{I_ADD, I_SUB};
    dispatch_ready = 1'b1;
    load_in_reset();
    got = pack_out();
    n_total++;
    if (got !== 58'd0) $display("FAIL reset_outputs: got %h expected 0", got);
    else n_pass++;
    release_rst();
    tick();
    n_total++;
    if (rename_valid !== 1'b0) $display("FAIL latency_cycle1: valid %b expected 0", rename_valid);
    else n_pass++;
    tick();
    n_total++;
    if (rename_valid !== 1'b1) $display("FAIL latency_cycle2: valid %b expected 1", rename_valid);
    else n_pass++;
    rst = 1'b1;
    #1;
    got = pack_out();
    n_total++;
    if (got !== 58'd0) $display("FAIL midop_reset: got %h expected 0", got);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [57:0] exp_t[5];
    logic [57:0] got;
    exp_t[0] = {1'b1, 7'd2,  7'd3,  7'd32, 4'd0, I_ADD};
    exp_t[1] = {1'b1, 7'd32, 7'd5,  7'd33, 4'd1, I_SUB};
    exp_t[2] = {1'b1, 7'd33, 7'd0,  7'd34, 4'd2, I_ADDI0};
    exp_t[3] = {1'b1, 7'd0,  7'd0,  7'd34, 4'd3, I_ADDI6};
    exp_t[4] = {1'b1, 7'd34, 7'd33, 7'd35, 4'd4, I_BEQ};
    prog = '{I_ADD, I_SUB, I_ADDI0, I_ADDI6, I_BEQ, 32'd0};
    dispatch_ready = 1'b1;
    load_in_reset();
    release_rst();
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      got = pack_out();
      n_total++;
      if (got !== exp_t[k]) $display("FAIL directed_op%0d: got %h expected %h", k, got, exp_t[k]);
      else n_pass++;
    end
    tick();
    n_total++;
    if (rename_valid !== 1'b0) $display("FAIL zero_word_bubble: valid %b expected 0", rename_valid);
    else n_pass++;
  endtask

  task automatic test_handshake();
    logic [57:0] add_t, sub_t, got;
    add_t = {1'b1, 7'd2,  7'd3, 7'd32, 4'd0, I_ADD};
    sub_t = {1'b1, 7'd32, 7'd5, 7'd33, 4'd1, I_SUB};
    prog = '{I_ADD, I_SUB, I_ADDI0, I_ADDI6, I_BEQ, 32'd0};
    dispatch_ready = 1'b1;
    load_in_reset();
    release_rst();
    tick();
    tick();
    dispatch_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      got = pack_out();
      n_total++;
      if (got !== add_t) $display("FAIL stall_hold%0d: got %h expected %h", k, got, add_t);
      else n_pass++;
    end
    dispatch_ready = 1'b1;
    tick();
    got = pack_out();
    n_total++;
    if (got !== sub_t) $display("FAIL stall_resume: got %h expected %h", got, sub_t);
    else n_pass++;
  endtask

  task automatic test_random(input int rounds);
    int mmap[32];
    int flq[$];
    int tagc, nv, p1, p2, pd, extra;
    logic [31:0] w;
    logic [6:0]  op;
    logic        lg, u1, u2, wr, held;
    logic [4:0]  s1, s2;
    logic [57:0] got, prev, e;
    for (int r = 0; r < rounds; r++) begin
      prog.delete();
      exp_q.delete();
      flq.delete();
      for (int i = 0; i < 32; i++) mmap[i] = i;
      for (int i = 32; i < 128; i++) flq.push_back(i);
      tagc = 0;
      nv = 0;
      for (int i = 0; i < 24; i++) begin
        w = $urandom();
        w[6:0] = ops[$urandom_range(0, 10)];
        if (nv == 16) w = 32'd0;
        prog.push_back(w);
        op = w[6:0];
        lg = 1'b1; u1 = 1'b0; u2 = 1'b0; wr = 1'b0;
        case (op)
          7'b0110011: begin u1 = 1'b1; u2 = 1'b1; wr = 1'b1; end
          7'b0010011, 7'b0000011, 7'b1100111: begin u1 = 1'b1; wr = 1'b1; end
          7'b0100011, 7'b1100011: begin u1 = 1'b1; u2 = 1'b1; end
          7'b0110111, 7'b0010111, 7'b1101111: wr = 1'b1;
          default: lg = 1'b0;
        endcase
        if (lg) begin
          s1 = u1 ? w[19:15] : 5'd0;
          s2 = u2 ? w[24:20] : 5'd0;
          p1 = mmap[s1];
          p2 = mmap[s2];
          pd = flq[0];
          if (wr && w[11:7] != 5'd0) mmap[w[11:7]] = flq.pop_front();
          exp_q.push_back({1'b1, 7'(p1), 7'(p2), 7'(pd), 4'(tagc), w});
          tagc = (tagc + 1) % 16;
          nv++;
        end
      end
      dispatch_ready = 1'b1;
      load_in_reset();
      release_rst();
      held = 1'b0;
      prev = '0;
      for (int cyc = 0; cyc < 300 && exp_q.size() > 0; cyc++) begin
        tick();
        got = pack_out();
        if (held) begin
          n_total++;
          if (got !== prev) $display("FAIL rand_hold r%0d: got %h expected %h", r, got, prev);
          else n_pass++;
        end else if (rename_valid) begin
          e = exp_q.pop_front();
          n_total++;
          if (got !== e) $display("FAIL rand_op r%0d: got %h expected %h", r, got, e);
          else n_pass++;
        end
        prev = got;
        dispatch_ready = ($urandom_range(0, 3) != 0);
        held = rename_valid && !dispatch_ready;
      end
      n_total++;
      if (exp_q.size() != 0) $display("FAIL rand_timeout r%0d: pending %0d expected 0", r, exp_q.size());
      else n_pass++;
      dispatch_ready = 1'b1;
      extra = 0;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (rename_valid && got !== pack_out()) extra++;
        got = pack_out();
      end
      n_total++;
      if (extra != 0) $display("FAIL rand_extra_ops r%0d: got %0d expected 0", r, extra);
      else n_pass++;
    end
  endtask

  task automatic test_rob_full();
    int nvalid;
    logic [3:0] last_tag;
    prog.delete();
    for (int i = 0; i < 20; i++) prog.push_back({12'(i), 5'd0, 3'b000, 5'(i + 1), 7'b0010011});
    dispatch_ready = 1'b1;
`ifdef OOO_RETIRE_PORT_EN
    retire_valid = 1'b0;
    retire_free_en = 1'b0;
    retire_free_preg = 7'd0;
`endif
    load_in_reset();
    release_rst();
    nvalid = 0;
    last_tag = 4'hx;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (rename_valid) begin
        nvalid++;
        last_tag = rename_rob_tag;
      end
    end
    n_total++;
    if (nvalid != 16) $display("FAIL rob_full_count: got %0d expected 16", nvalid);
    else n_pass++;
    n_total++;
    if (last_tag !== 4'd15) $display("FAIL rob_full_last_tag: got %0d expected 15", last_tag);
    else n_pass++;
    n_total++;
    if (rename_valid !== 1'b0) $display("FAIL rob_full_stall: valid %b expected 0", rename_valid);
    else n_pass++;
`ifdef OOO_RETIRE_PORT_EN
    retire_valid = 1'b1;
    retire_free_en = 1'b1;
    retire_free_preg = 7'd5;
    tick();
    retire_valid = 1'b0;
    retire_free_en = 1'b0;
    for (int c = 0; c < 5 && !rename_valid; c++) tick();
    n_total++;
    if ({rename_valid, rename_prs1, rename_prd, rename_rob_tag} !== {1'b1, 7'd0, 7'd48, 4'd0})
      $display("FAIL retire_resume: got v%b prs1 %0d prd %0d tag %0d expected v1 prs1 0 prd 48 tag 0",
               rename_valid, rename_prs1, rename_prd, rename_rob_tag);
    else n_pass++;
`endif
  endtask

  initial begin
    rst = 1'b1;
    imem_we = 1'b0;
    imem_waddr = 8'd0;
    imem_wdata = 32'd0;
    dispatch_ready = 1'b1;
`ifdef OOO_RETIRE_PORT_EN
    retire_valid = 1'b0;
    retire_free_preg = 7'd0;
    retire_free_en = 1'b0;
`endif
    test_reset();
    test_directed();
    test_handshake();
    test_random(4);
    test_rob_full();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ooo_rename_frontend.md
Name: ooo_rename_frontend

Overview:
- In-order front end of the out-of-order core: fetches 32-bit RV32I instructions from an internal word-addressed instruction memory, decodes the register fields, and renames them through a map table, a physical-register free list and a ROB tag counter.
- The renamed micro-op is presented registered toward the dispatch skid buffer.
- No execution or commit happens in this block; physical registers and ROB tags are returned only via the optional retire port.

Parameters:
- XLEN, 32, instruction width.
- IMEM_DEPTH, 256, instruction-memory words.
- PHYS_REGS, 128, physical register count (tag width 7).
- ROB_DEPTH, 16, ROB entries (tag width 4).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_we  in  1  instruction-memory write strobe (program load).
- imem_waddr  in  8  write word address.
- imem_wdata  in  32  write data.
- dispatch_ready  in  1  downstream accepts the current renamed op.
- rename_valid  out  1  renamed op valid.
- rename_prs1  out  7  physical source 1.
- rename_prs2  out  7  physical source 2.
- rename_prd  out  7  physical destination (free-list head).
- rename_rob_tag  out  4  ROB tag.
- rename_instr  out  32  raw instruction, for downstream decode.

Behaviour:
- Reset (async, active-high):
  - PC=0; map table entry i = Pi for i=0..31.
  - Free list holds P32..P127 in order; head points at P32.
  - ROB tag counter=0; all outputs 0, rename_valid=0.
- Fetch:
  - Memory read is synchronous, 1-cycle latency.
  - PC advances by 1 word per cycle unless stalled.
  - First rename_valid asserts 2 cycles after rst deasserts (PC=0 instr).
  - Then one op per cycle while not stalled.
- Decode:
  - rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7].
  - R-type (0110011): uses rs1, rs2; writes rd.
  - I-ALU/load/JALR (0010011/0000011/1100111): uses rs1; rs2 forced to x0; writes rd.
  - S/B (0100011/1100011): uses rs1, rs2; no write.
  - LUI/AUIPC/JAL: rs1 = rs2 = x0; writes rd.
  - Opcode 0000000 or unknown is a bubble: rename_valid=0, no tag or register consumed, PC still advances.
- Rename (one op per cycle, outputs registered):
  - prs1 = map[rs1] and prs2 = map[rs2], read after the map update by the previous op, so back-to-back RAW returns the new mapping.
  - x0 always maps to P0.
  - rename_prd always shows the current free-list head.
  - Allocation happens only if the op writes and rd≠0: head advances and map[rd] = head.
  - An x0 write or a no-write op leaves head and map unchanged.
  - rob_tag = counter; counter increments (mod 16) per valid op.
- Handshake:
  - If rename_valid=1 and dispatch_ready=0, all outputs hold and fetch/rename stall; no state advances.
- Structural stalls (rename_valid held 0, PC holds):
  - free list empty and the op needs allocation; or
  - 16 ops in flight (ROB full).
  - Free-list pointers wrap modulo 96.
- Program-load writes are accepted any cycle.
- Reset mid-operation discards all in-flight state immediately.

Optional Feature:
- Macro: OOO_RETIRE_PORT_EN.
- With the macro defined, the block adds these inputs:
  - retire_valid (1)
  - retire_free_preg (7)
  - retire_free_en (1)
- Effects of each retire:
  - Decrements the in-flight count, freeing one ROB slot.
  - If retire_free_en=1 and retire_free_preg≠0, pushes that register at the free-list tail.
  - Retire and allocate may occur in the same cycle; both take effect.
- Without the macro, resources never return and the block stalls after 96 allocations or 16 ops.

Test Plan:
- Load ADD x1,x2,x3; rst 10 cycles, release -> first valid op: prs1=2, prs2=3, prd=32, tag=0.
- Next: SUB x4,x1,x5 -> prs1=32 (RAW), prs2=5, prd=33, tag=1.
- Next: ADDI x0,x4,10 -> prs1=33, prs2=0, prd=34 shown but not allocated, tag=2.
  - Then ADDI x6,x0,100 -> prs1=0, prs2=0, prd=34, tag=3.
- Next: BEQ x6,x4,8 -> prs1=34, prs2=33, prd=35 not allocated, tag=4.
  - Following zero word -> rename_valid=0.
- Hold dispatch_ready=0 for 3 cycles mid-stream -> outputs frozen, tags/prd unchanged on resume.
- 17 writing ops, no retire -> the 17th stalls with rename_valid=0.
  - With OOO_RETIRE_PORT_EN, one retire -> it proceeds with tag=0 (wrapped).
